apb_master_arbiter: RTL and testbench

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

---
 rtl/apb_master_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin sharing of one APB master port among NO_OF_MASTERS requesters.
// Optional ACCESS wait-state timeout is built in when APB_ARB_TIMEOUT_EN is defined.
module apb_master_arbiter #(
  parameter int NO_OF_MASTERS = 5,
  parameter int NO_OF_SLAVES  = 5,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int REGION_BYTES  = 16384,
  parameter int MAX_WAIT      = 16
) (
  input  logic                                     pclk,
  input  logic                                     preset,
  input  logic [NO_OF_MASTERS-1:0]                 req,
  input  logic [NO_OF_MASTERS-1:0]                 req_write,
  input  logic [NO_OF_MASTERS*ADDRESS_WIDTH-1:0]   req_addr,
  input  logic [NO_OF_MASTERS*DATA_WIDTH-1:0]      req_wdata,
  input  logic [NO_OF_MASTERS*(DATA_WIDTH/8)-1:0]  req_strb,
  input  logic [NO_OF_MASTERS*3-1:0]               req_prot,
  output logic [NO_OF_MASTERS-1:0]                 gnt,
  output logic [NO_OF_MASTERS-1:0]                 done,
  output logic [DATA_WIDTH-1:0]                    rdata,
  output logic                                     slverr,
  output logic [NO_OF_SLAVES-1:0]                  psel,
  output logic                                     penable,
  output logic                                     pwrite,
  output logic [ADDRESS_WIDTH-1:0]                 paddr,
  output logic [DATA_WIDTH-1:0]                    pwdata,
  output logic [DATA_WIDTH/8-1:0]                  pstrb,
  output logic [2:0]                               pprot,
  input  logic                                     pready,
  input  logic                                     pslverr,
  input  logic [DATA_WIDTH-1:0]                    prdata
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int PW = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                   r_state;
  logic [PW-1:0]            r_ptr;
  logic                     r_decerr;

  logic [NO_OF_MASTERS-1:0] w_cand;
  logic [NO_OF_MASTERS-1:0] w_gnt;
  logic [PW-1:0]            w_k;
  logic [PW-1:0]            w_win;
  logic [PW-1:0]            w_ptr_nxt;
  logic                     w_any;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [ADDRESS_WIDTH-1:0] w_idx;
  logic [DATA_WIDTH-1:0]    w_wdata;
  logic [SW-1:0]            w_strb;
  logic [2:0]               w_prot;
  logic                     w_write;
  logic [NO_OF_SLAVES-1:0]  w_psel;
  logic                     w_decerr;
  logic                     w_timeout;
  logic                     w_finish;
  logic                     w_load;

  // The current owner is masked out, so at completion another requester wins if one is waiting;
  // gnt is zero in IDLE, so the mask is a no-op there.
  always_comb begin
    w_cand = req & ~gnt;
    w_any  = 1'b0;
    w_win  = '0;
    w_k    = '0;
    for (int unsigned i = 0; i < NO_OF_MASTERS; i++) begin
      w_k = PW'((32'(r_ptr) + i) % 32'(NO_OF_MASTERS));
      if (!w_any && w_cand[w_k]) begin
        w_any = 1'b1;
        w_win = w_k;
      end
    end
    w_gnt        = '0;
    w_gnt[w_win] = 1'b1;
    w_ptr_nxt    = (w_win == PW'(NO_OF_MASTERS - 1)) ? '0 : w_win + PW'(1);
  end

  always_comb begin
    w_addr   = req_addr[32'(w_win)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    w_wdata  = req_wdata[32'(w_win)*DATA_WIDTH +: DATA_WIDTH];
    w_strb   = req_strb[32'(w_win)*SW +: SW];
    w_prot   = req_prot[32'(w_win)*3 +: 3];
    w_write  = req_write[w_win];
    w_idx    = w_addr / ADDRESS_WIDTH'(REGION_BYTES);
    w_decerr = (w_idx >= ADDRESS_WIDTH'(NO_OF_SLAVES));
    w_psel   = '0;
    for (int unsigned s = 0; s < NO_OF_SLAVES; s++) begin
      if (w_idx == ADDRESS_WIDTH'(s)) w_psel[s] = 1'b1;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  logic [WW-1:0] r_wait;

  assign w_timeout = !pready && (r_wait == WW'(MAX_WAIT - 1));
`else
  assign w_timeout = 1'b0;
  // MAX_WAIT has no effect without the timeout; referenced here so the parameter stays in use.
  if (MAX_WAIT < 1) begin : g_max_wait_unused
  end
`endif

  // A decode error finishes on its first ACCESS cycle whatever pready says.
  assign w_finish = r_decerr || pready || w_timeout;
  assign w_load   = w_any && ((r_state == IDLE) || ((r_state == ACCESS) && w_finish));

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_decerr <= 1'b0;
      gnt      <= '0;
      done     <= '0;
      rdata    <= '0;
      slverr   <= 1'b0;
      psel     <= '0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      pstrb    <= '0;
      pprot    <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      r_wait   <= '0;
`endif
    end else begin
      done <= '0;
      case (r_state)
        IDLE: begin
        end
        SETUP: begin
          penable <= 1'b1;
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (w_finish) begin
            done    <= gnt;
            penable <= 1'b0;
            if (r_decerr || w_timeout) begin
              slverr <= 1'b1;
              rdata  <= '0;
            end else begin
              slverr <= pslverr;
              if (!pwrite) rdata <= prdata;
            end
            if (!w_any) begin
              r_state <= IDLE;
              gnt     <= '0;
              psel    <= '0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_load) begin
        r_state  <= SETUP;
        gnt      <= w_gnt;
        r_ptr    <= w_ptr_nxt;
        psel     <= w_psel;
        r_decerr <= w_decerr;
        paddr    <= w_addr;
        pwrite   <= w_write;
        pwdata   <= w_wdata;
        pstrb    <= w_strb;
        pprot    <= w_prot;
      end

`ifdef APB_ARB_TIMEOUT_EN
      if ((r_state == ACCESS) && !w_finish) r_wait <= r_wait + WW'(1);
      else                                   r_wait <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed scoreboard bench for apb_master_arbiter; honours APB_ARB_TIMEOUT_EN like the design.
module tb_apb_master_arbiter;

  localparam int NM = 5;
  localparam int NS = 5;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              pclk = 1'b0;
  logic              preset;
  logic [NM-1:0]     req, req_write;
  logic [NM*AW-1:0]  req_addr;
  logic [NM*DW-1:0]  req_wdata;
  logic [NM*SW-1:0]  req_strb;
  logic [NM*3-1:0]   req_prot;
  logic [NM-1:0]     gnt, done;
  logic [DW-1:0]     rdata;
  logic              slverr;
  logic [NS-1:0]     psel;
  logic              penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [SW-1:0]     pstrb;
  logic [2:0]        pprot;
  logic              pready, pslverr;
  logic [DW-1:0]     prdata;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(
    .NO_OF_MASTERS(NM),
    .NO_OF_SLAVES (NS),
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .REGION_BYTES (16384),
    .MAX_WAIT     (16)
  ) dut (
    .pclk(pclk), .preset(preset),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_strb(req_strb), .req_prot(req_prot),
    .gnt(gnt), .done(done), .rdata(rdata), .slverr(slverr),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  typedef struct {
    int            m;
    logic [NS-1:0] psel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          wr;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    logic [DW-1:0] rdata;
    logic          slverr;
    int            acc;
    int            lat;
    int            t0;
    bit            b2b;
    bit            drop;
    bit            idle_after;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            acc_cnt = 0;
  int            last_done = 0;
  int            done_seen = 0;
  int            waits = 0;
  logic [DW-1:0] rd_val = '0;
  logic          err_val = 1'b0;
  logic [NM-1:0] hold = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int m, input logic wr, input logic [AW-1:0] a,
                              input logic [DW-1:0] wd, input logic [NS-1:0] ps,
                              input logic [DW-1:0] rd, input logic se, input int acc, input int lat);
    exp_t e;
    e.m = m; e.wr = wr; e.addr = a; e.wdata = wd; e.psel = ps;
    e.strb = SW'(m + 3); e.prot = 3'(m);
    e.rdata = rd; e.slverr = se; e.acc = acc; e.lat = lat; e.t0 = cyc;
    e.b2b = 1'b0; e.drop = 1'b0; e.idle_after = 1'b1;
    return e;
  endfunction

  task automatic drv(input exp_t e);
    req_write[e.m]          = e.wr;
    req_addr[e.m*AW +: AW]  = e.addr;
    req_wdata[e.m*DW +: DW] = e.wdata;
    req_strb[e.m*SW +: SW]  = e.strb;
    req_prot[e.m*3 +: 3]    = e.prot;
    req[e.m]                = 1'b1;
  endtask

  // One clock: observe at the falling edge, score completions/SETUPs, then drive the slave side.
  task automatic step();
    exp_t e;
    @(negedge pclk);
    cyc++;
    if (done != '0) begin
      done_seen++;
      if (sb.size() == 0) chk("unexpected_done", 64'(done), 64'(0));
      else begin
        e = sb.pop_front();
        chk("done_owner", 64'(done), 64'(NM'(1) << e.m));
        chk("rdata", 64'(rdata), 64'(e.rdata));
        chk("slverr", 64'(slverr), 64'(e.slverr));
        chk("access_cycles", 64'(acc_cnt), 64'(e.acc));
        if (e.lat > 0) chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        if (e.b2b) chk("b2b_gap", 64'(cyc - last_done), 64'(2));
        if (e.idle_after) chk("idle_psel_gnt", 64'({psel, gnt}), 64'(0));
        last_done = cyc;
        if (!hold[e.m]) req[e.m] = 1'b0;
      end
    end
    if (gnt != '0 && !penable) begin
      if (sb.size() == 0) chk("unexpected_setup", 64'(gnt), 64'(0));
      else begin
        chk("setup_gnt", 64'(gnt), 64'(NM'(1) << sb[0].m));
        chk("setup_psel", 64'(psel), 64'(sb[0].psel));
        chk("setup_paddr", 64'(paddr), 64'(sb[0].addr));
        chk("setup_pwrite", 64'(pwrite), 64'(sb[0].wr));
        chk("setup_pwdata", 64'(pwdata), 64'(sb[0].wdata));
        chk("setup_pstrb_pprot", 64'({pstrb, pprot}), 64'({sb[0].strb, sb[0].prot}));
        if (sb[0].drop) begin
          req  = '0;
          hold = '0;
        end
      end
      acc_cnt = 0;
    end
    if (penable) begin
      acc_cnt++;
      pready = (acc_cnt > waits);
    end else begin
      pready = 1'b0;
    end
    prdata  = pready ? rd_val : 32'hDEAD_BEEF;
    pslverr = pready ? err_val : 1'b0;
  endtask

  task automatic run_until(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      step();
      n++;
    end
    chk("drain_within_budget", 64'(sb.size()), 64'(0));
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, "_psel"},    64'(psel),    64'(0));
    chk({p, "_penable"}, 64'(penable), 64'(0));
    chk({p, "_pwrite"},  64'(pwrite),  64'(0));
    chk({p, "_paddr"},   64'(paddr),   64'(0));
    chk({p, "_pwdata"},  64'(pwdata),  64'(0));
    chk({p, "_pstrb"},   64'(pstrb),   64'(0));
    chk({p, "_pprot"},   64'(pprot),   64'(0));
    chk({p, "_gnt"},     64'(gnt),     64'(0));
    chk({p, "_done"},    64'(done),    64'(0));
    chk({p, "_rdata"},   64'(rdata),   64'(0));
    chk({p, "_slverr"},  64'(slverr),  64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   d0;
    preset = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    req_strb = '0; req_prot = '0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    step(); step();
    chk_all_zero("reset");
    preset = 1'b0;

    // Single write, zero wait states: SETUP, one ACCESS, done three cycles after req.
    waits = 0; err_val = 1'b0; rd_val = 32'hFFFF_0000;
    e = mk(0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 5'b00001, 32'h0, 1'b0, 1, 3);
    drv(e); sb.push_back(e); run_until(20);

    // Read with three wait states lands in slave 2.
    waits = 3; rd_val = 32'h1234_5678;
    e = mk(1, 1'b0, 32'h0000_8004, 32'h0, 5'b00100, 32'h1234_5678, 1'b0, 4, 6);
    drv(e); sb.push_back(e); run_until(20);

    // Write with slave error: rdata must keep the last read value.
    waits = 1; err_val = 1'b1; rd_val = 32'h9999_9999;
    e = mk(3, 1'b1, 32'h0000_4000, 32'h0BAD_F00D, 5'b00010, 32'h1234_5678, 1'b1, 2, 0);
    drv(e); sb.push_back(e); run_until(20);

    // Decode error (index 5): no psel, completes first ACCESS cycle even with pready low.
    waits = 5; err_val = 1'b0; rd_val = 32'hCAFE_BABE;
    e = mk(4, 1'b0, 32'h0001_4000, 32'h0, 5'b00000, 32'h0, 1'b1, 1, 0);
    drv(e); sb.push_back(e); run_until(20);

    // Contention: 0,2,4 held high -> 0,2,4,0 back-to-back; all drop during the second 0 transfer.
    waits = 0; err_val = 1'b0; rd_val = 32'h600D_0002; hold = 5'b10101;
    e = mk(0, 1'b1, 32'h0000_0010, 32'h1111_1111, 5'b00001, 32'h0, 1'b0, 1, 3);
    e.idle_after = 1'b0; drv(e); sb.push_back(e);
    e = mk(2, 1'b0, 32'h0000_8008, 32'h0, 5'b00100, 32'h600D_0002, 1'b0, 1, 0);
    e.idle_after = 1'b0; e.b2b = 1'b1; drv(e); sb.push_back(e);
    e = mk(4, 1'b1, 32'h0001_0000, 32'h4444_4444, 5'b10000, 32'h600D_0002, 1'b0, 1, 0);
    e.idle_after = 1'b0; e.b2b = 1'b1; drv(e); sb.push_back(e);
    e = mk(0, 1'b1, 32'h0000_0010, 32'h1111_1111, 5'b00001, 32'h600D_0002, 1'b0, 1, 0);
    e.b2b = 1'b1; e.drop = 1'b1; sb.push_back(e);
    run_until(40);

    // pready held low forever.
    waits = 100000; rd_val = 32'h7777_7777;
    e = mk(1, 1'b0, 32'h0000_4004, 32'h0, 5'b00010, 32'h0, 1'b1, 16, 0);
    drv(e); sb.push_back(e);
`ifdef APB_ARB_TIMEOUT_EN
    run_until(40);
    e = mk(2, 1'b0, 32'h0000_8004, 32'h0, 5'b00100, 32'h0, 1'b0, 1, 0);
    drv(e); sb.push_back(e);
`else
    d0 = done_seen;
    repeat (100) step();
    chk("no_done_without_timeout", 64'(done_seen - d0), 64'(0));
    chk("still_in_access", 64'(penable), 64'(1));
`endif

    // Reset in ACCESS aborts silently and rewinds the round-robin pointer.
    for (int i = 0; i < 10 && !penable; i++) step();
    chk("access_before_reset", 64'(penable), 64'(1));
    preset = 1'b1; req = '0; hold = '0;
    d0 = done_seen;
    step();
    chk_all_zero("midreset");
    step();
    chk("no_done_in_reset", 64'(done_seen - d0), 64'(0));
    sb.delete();
    preset = 1'b0; waits = 0; err_val = 1'b0; rd_val = 32'h0;
    e = mk(0, 1'b1, 32'h0000_0020, 32'hFEED_0000, 5'b00001, 32'h0, 1'b0, 1, 3);
    e.idle_after = 1'b0; drv(e); sb.push_back(e);
    e = mk(4, 1'b1, 32'h0000_C000, 32'h4040_4040, 5'b01000, 32'h0, 1'b0, 1, 0);
    e.b2b = 1'b1; drv(e); sb.push_back(e);
    run_until(20);

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
